spi_periphery_sync: RTL and testbench
=====================================

// Module: spi_periphery_sync
// PURPOSE
//  Peripheral-side SPI responder running in the system clk domain. Pairs with SPI_Controller's half-duplex frame:
//  controller shifts LENGTH_RECIEVED bits in on COPI, pauses, then clocks LENGTH_SEND bits back on CIPO.
//  SCK/CS/COPI are oversampled through synchronizers, so the block integrates directly with clk-domain logic.
//  Exposes a load handshake for the reply word and a one-cycle strobe for each received word.
// PARAMETERS
//  LENGTH_SEND      8  reply word width (periphery->controller, on CIPO)
//  LENGTH_RECIEVED  8  command word width (controller->periphery, on COPI)
//  SYNC_STAGES      2  synchronizer flops on SCK, CS, COPI (>=2)
// PORTS
//  clk            in   1                 system clock; must be >= 4x SCK frequency
//  rst            in   1                 asynchronous, active-low reset
//  SCK            in   1                 serial clock from controller, idle low
//  CS             in   1                 chip select, active low
//  COPI           in   1                 serial data in, MSB first
//  CIPO           out  1                 serial data out, MSB first
//  data_send      in   LENGTH_SEND       reply word, captured on send_valid&&send_ready
//  send_valid     in   1                 reply word offered
//  send_ready     out  1                 high only in IDLE
//  COPI_register  out  LENGTH_RECIEVED   last complete received word
//  rx_valid       out  1                 1-cycle pulse when COPI_register updates
//  busy           out  1                 high when state != IDLE
//  frame_err      out  1                 1-cycle pulse on CS deasserted mid-frame
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, CIPO=0, COPI_register=0, rx_valid=0, frame_err=0, busy=0, tx_loaded=0,
//   synchronizers cleared to SCK=0, CS=1, COPI=0; send_ready=1 (combinational: state==IDLE).
//  Sampling: edges detected on synchronized SCK/CS vs. one extra delay flop; edge acted on SYNC_STAGES+1 clk after pin.
//  Load: send_valid&&send_ready -> tx_shift<=data_send, tx_loaded=1; a repeat load in IDLE overwrites.
//  FSM IDLE -> RX -> TX -> DONE -> IDLE.
//  IDLE: CIPO=0. Synced CS falling -> RX, bit_cnt=0, rx_shift=0.
//  RX: each SCK rising: rx_shift<={rx_shift[L-2:0],COPI_sync}, bit_cnt++. On the LENGTH_RECIEVED-th rising edge:
//   COPI_register<=completed word and rx_valid=1 on the same clk; -> TX, bit_cnt=0,
//   CIPO<=tx_shift MSB (or 0 if !tx_loaded). SCK falling edges in RX are ignored.
//  TX: CIPO held stable across the inter-phase pause. Each SCK rising: bit_cnt++ (controller samples).
//   Each SCK falling: tx_shift shifts left, CIPO<=next bit. After LENGTH_SEND rising edges -> DONE.
//   !tx_loaded: all-zero reply, no error flagged.
//  DONE: CIPO=0; further SCK edges ignored; synced CS rising -> IDLE, tx_loaded=0.
//  CS rising while in RX or TX: -> IDLE next clk, frame_err=1 for 1 clk, CIPO=0, COPI_register and rx_valid untouched,
//   tx_loaded=0. CS falling in DONE/TX is not possible without an intervening rising edge; no special case needed.
//  Simultaneous: SCK edge and CS rising detected on the same clk -> CS wins (edge discarded).
//  bit_cnt width $clog2(max(LENGTH_SEND,LENGTH_RECIEVED)+1); never wraps inside a frame.
// TESTING
//  1 Load 8'hA5, frame with COPI=8'h3C, pause 5 SCK, 8 reply clocks -> COPI_register=8'h3C with one rx_valid pulse; controller sees 8'hA5.
//  2 Two back-to-back frames (CS high 2 SCK periods between), loads 8'h01 then 8'hFE -> replies 8'h01, 8'hFE; rx_valid once per frame.
//  3 No load before frame, COPI=8'hFF -> COPI_register=8'hFF, CIPO all zeros, frame_err=0.
//  4 CS raised after 4 RX bits -> frame_err pulse 1 clk, COPI_register keeps prior value, state IDLE, send_ready=1.
//  5 rst asserted mid-TX asynchronously -> all outputs at reset values immediately; next full frame completes correctly.
//  6 SCK at clk/4 with COPI changing on SCK falling edges (mode 0 timing) -> no bit slips over 100 random frames.

Source files
------------

// File: rtl/spi_periphery_sync.sv
// SPI peripheral responder in the clk domain: receives a command word on COPI, then
// returns a preloaded reply word on CIPO. SCK/CS/COPI are synchronized and edge-detected.
module spi_periphery_sync #(
  parameter int unsigned LENGTH_SEND     = 8,
  parameter int unsigned LENGTH_RECIEVED = 8,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       SCK,
  input  logic                       CS,
  input  logic                       COPI,
  output logic                       CIPO,
  input  logic [LENGTH_SEND-1:0]     data_send,
  input  logic                       send_valid,
  output logic                       send_ready,
  output logic [LENGTH_RECIEVED-1:0] COPI_register,
  output logic                       rx_valid,
  output logic                       busy,
  output logic                       frame_err
);

  localparam int unsigned MAX_LEN = (LENGTH_SEND > LENGTH_RECIEVED) ? LENGTH_SEND : LENGTH_RECIEVED;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, RX, TX, DONE} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           bit_cnt, bit_cnt_nxt;
  logic [LENGTH_RECIEVED-1:0] rx_shift, rx_shift_nxt;
  logic [LENGTH_SEND-1:0]     tx_shift, tx_shift_nxt;
  logic                       tx_loaded, tx_loaded_nxt;
  logic                       cipo_nxt;
  logic [LENGTH_RECIEVED-1:0] copi_reg_nxt;
  logic                       rx_valid_nxt, frame_err_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, copi_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, copi_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall, load;

  // Input synchronizers plus one delay flop for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      copi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign copi_s     = copi_sync[SYNC_STAGES-1];
  assign sck_rise   = sck_s & ~sck_d;
  assign sck_fall   = ~sck_s & sck_d;
  assign cs_rise    = cs_s & ~cs_d;
  assign cs_fall    = ~cs_s & cs_d;
  assign send_ready = (state == IDLE);
  assign load       = send_valid & send_ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      tx_loaded     <= 1'b0;
      CIPO          <= 1'b0;
      COPI_register <= '0;
      rx_valid      <= 1'b0;
      frame_err     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      bit_cnt       <= bit_cnt_nxt;
      rx_shift      <= rx_shift_nxt;
      tx_shift      <= tx_shift_nxt;
      tx_loaded     <= tx_loaded_nxt;
      CIPO          <= cipo_nxt;
      COPI_register <= copi_reg_nxt;
      rx_valid      <= rx_valid_nxt;
      frame_err     <= frame_err_nxt;
      busy          <= (state_nxt != IDLE);
    end
  end

  // Next-state and output logic; a CS rising edge always takes priority over SCK edges
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    rx_shift_nxt  = rx_shift;
    tx_shift_nxt  = tx_shift;
    tx_loaded_nxt = tx_loaded;
    cipo_nxt      = CIPO;
    copi_reg_nxt  = COPI_register;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;

    case (state)
      IDLE: begin
        cipo_nxt = 1'b0;
        if (load) begin
          tx_shift_nxt  = data_send;
          tx_loaded_nxt = 1'b1;
        end
        if (cs_fall) begin
          state_nxt    = RX;
          bit_cnt_nxt  = '0;
          rx_shift_nxt = '0;
        end
      end

      RX: begin
        if (cs_rise) begin
          state_nxt     = IDLE;
          frame_err_nxt = 1'b1;
          cipo_nxt      = 1'b0;
          tx_loaded_nxt = 1'b0;
        end else if (sck_rise) begin
          rx_shift_nxt = {rx_shift[LENGTH_RECIEVED-2:0], copi_s};
          if (bit_cnt == CNT_W'(LENGTH_RECIEVED - 1)) begin
            copi_reg_nxt = {rx_shift[LENGTH_RECIEVED-2:0], copi_s};
            rx_valid_nxt = 1'b1;
            state_nxt    = TX;
            bit_cnt_nxt  = '0;
            cipo_nxt     = tx_loaded & tx_shift[LENGTH_SEND-1];
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end

      TX: begin
        if (cs_rise) begin
          state_nxt     = IDLE;
          frame_err_nxt = 1'b1;
          cipo_nxt      = 1'b0;
          tx_loaded_nxt = 1'b0;
        end else if (sck_rise) begin
          if (bit_cnt == CNT_W'(LENGTH_SEND - 1)) begin
            state_nxt = DONE;
            cipo_nxt  = 1'b0;
          end
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end else if (sck_fall && (bit_cnt != '0)) begin
          // The falling edge that closes the last RX bit arrives with bit_cnt==0 and must not shift
          tx_shift_nxt = {tx_shift[LENGTH_SEND-2:0], 1'b0};
          cipo_nxt     = tx_loaded & tx_shift[LENGTH_SEND-2];
        end
      end

      DONE: begin
        cipo_nxt = 1'b0;
        if (cs_rise) begin
          state_nxt     = IDLE;
          tx_loaded_nxt = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_periphery_sync.sv
// Directed bench for spi_periphery_sync: a cycle-timed SPI controller drives frames and
// the received command words, replies and status pulses are compared to hand-computed values.
module tb_spi_periphery_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       SCK = 1'b0;
  logic       CS = 1'b1;
  logic       COPI = 1'b0;
  logic       CIPO;
  logic [7:0] data_send = '0;
  logic       send_valid = 1'b0;
  logic       send_ready;
  logic [7:0] COPI_register;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int rx_pulses = 0;
  int ferr_pulses = 0;

  spi_periphery_sync #(.LENGTH_SEND(8), .LENGTH_RECIEVED(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .SCK(SCK), .CS(CS), .COPI(COPI), .CIPO(CIPO),
    .data_send(data_send), .send_valid(send_valid), .send_ready(send_ready),
    .COPI_register(COPI_register), .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_valid)  rx_pulses   <= rx_pulses + 1;
    if (frame_err) ferr_pulses <= ferr_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_word(input logic [7:0] w);
    int t = 0;
    while (!send_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("load_ready_timeout", 32'(send_ready), 32'd1);
    data_send  = w;
    send_valid = 1'b1;
    @(negedge clk);
    send_valid = 1'b0;
  endtask

  task automatic cs_low(input int h);
    CS = 1'b0;
    wait_clk(h);
  endtask

  task automatic rx_bits(input logic [7:0] w, input int n, input int h);
    for (int i = 7; i > 7 - n; i--) begin
      COPI = w[i];
      wait_clk(h);
      SCK = 1'b1;
      wait_clk(h);
      SCK = 1'b0;
    end
  endtask

  task automatic tx_bits(input int n, input int h, output logic [7:0] reply);
    reply = '0;
    for (int i = 0; i < n; i++) begin
      wait_clk(h);
      SCK = 1'b1;
      reply = {reply[6:0], CIPO};
      wait_clk(h);
      SCK = 1'b0;
    end
  endtask

  task automatic cs_high(input int h);
    wait_clk(h);
    CS = 1'b1;
    wait_clk(2 * h + 6);
  endtask

  task automatic frame(input logic [7:0] cmd, input int h, output logic [7:0] reply);
    cs_low(h);
    rx_bits(cmd, 8, h);
    wait_clk(5 * 2 * h);
    tx_bits(8, h, reply);
    cs_high(h);
  endtask

  initial begin
    logic [7:0] reply;
    logic [7:0] cmd;
    int rx0, fe0;

    #1;
    check("rst_cipo", 32'(CIPO), 32'd0);
    check("rst_copi_register", 32'(COPI_register), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_send_ready", 32'(send_ready), 32'd1);
    wait_clk(3);
    rst = 1'b1;
    wait_clk(3);

    // 1: basic frame
    rx0 = rx_pulses; fe0 = ferr_pulses;
    load_word(8'hA5);
    frame(8'h3C, 4, reply);
    check("t1_copi_register", 32'(COPI_register), 32'h3C);
    check("t1_reply", 32'(reply), 32'hA5);
    check("t1_rx_pulses", 32'(rx_pulses - rx0), 32'd1);
    check("t1_frame_err", 32'(ferr_pulses - fe0), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);

    // 2: back-to-back frames
    rx0 = rx_pulses;
    load_word(8'h01);
    frame(8'h5A, 4, reply);
    check("t2_reply_a", 32'(reply), 32'h01);
    check("t2_copi_a", 32'(COPI_register), 32'h5A);
    load_word(8'hFE);
    frame(8'h81, 4, reply);
    check("t2_reply_b", 32'(reply), 32'hFE);
    check("t2_copi_b", 32'(COPI_register), 32'h81);
    check("t2_rx_pulses", 32'(rx_pulses - rx0), 32'd2);

    // 3: no reply loaded
    fe0 = ferr_pulses;
    frame(8'hFF, 4, reply);
    check("t3_copi_register", 32'(COPI_register), 32'hFF);
    check("t3_reply_zero", 32'(reply), 32'h00);
    check("t3_frame_err", 32'(ferr_pulses - fe0), 32'd0);

    // 4: CS raised after 4 RX bits
    rx0 = rx_pulses; fe0 = ferr_pulses;
    load_word(8'h77);
    cs_low(4);
    rx_bits(8'h12, 4, 4);
    check("t4_busy_mid", 32'(busy), 32'd1);
    check("t4_send_ready_mid", 32'(send_ready), 32'd0);
    cs_high(4);
    check("t4_frame_err_pulses", 32'(ferr_pulses - fe0), 32'd1);
    check("t4_copi_kept", 32'(COPI_register), 32'hFF);
    check("t4_rx_pulses", 32'(rx_pulses - rx0), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_send_ready", 32'(send_ready), 32'd1);
    // tx_loaded was cleared by the abort, so the next reply is zero
    frame(8'h24, 4, reply);
    check("t4_next_reply", 32'(reply), 32'h00);
    check("t4_next_copi", 32'(COPI_register), 32'h24);

    // 5: async reset in the middle of TX
    load_word(8'hFF);
    cs_low(4);
    rx_bits(8'h99, 8, 4);
    wait_clk(10);
    tx_bits(3, 4, reply);
    wait_clk(8);
    check("t5_cipo_before", 32'(CIPO), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t5_cipo", 32'(CIPO), 32'd0);
    check("t5_copi_register", 32'(COPI_register), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_rx_valid", 32'(rx_valid), 32'd0);
    check("t5_frame_err", 32'(frame_err), 32'd0);
    check("t5_send_ready", 32'(send_ready), 32'd1);
    CS = 1'b1;
    SCK = 1'b0;
    wait_clk(3);
    rst = 1'b1;
    wait_clk(3);
    load_word(8'h6B);
    frame(8'hD2, 4, reply);
    check("t5_after_reply", 32'(reply), 32'h6B);
    check("t5_after_copi", 32'(COPI_register), 32'hD2);

    // 6: SCK at clk/4, random command words
    rx0 = rx_pulses;
    for (int f = 0; f < 100; f++) begin
      cmd = 8'($urandom_range(0, 255));
      frame(cmd, 2, reply);
      check("t6_copi_register", 32'(COPI_register), 32'(cmd));
    end
    check("t6_rx_pulses", 32'(rx_pulses - rx0), 32'd100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
